// File: rtl/cordic_sin_cos_if.sv
`default_nettype none
// ==========================================================================
// cordic_sin_cos_if : request/result bundle for the CORDIC sin/cos engine
// Revision 1.0
// ==========================================================================
interface cordic_sin_cos_if;
   logic               valid_in;
   logic        [31:0] angle_ieee754;
   logic signed [15:0] cos_q15;
   logic signed [15:0] sin_q15;
   logic               valid;

   modport master (
      output valid_in,
      output angle_ieee754,
      input  cos_q15,
      input  sin_q15,
      input  valid
   );

   modport slave (
      input  valid_in,
      input  angle_ieee754,
      output cos_q15,
      output sin_q15,
      output valid
   );
endinterface
`default_nettype wire

// File: rtl/cordic_sin_cos.sv
`default_nettype none
// ==========================================================================
// cordic_sin_cos : iterative CORDIC sin/cos of an IEEE-754 angle in degrees
// Revision 1.0
// ==========================================================================
module cordic_sin_cos #(
   parameter int ITER = 16
) (
   input  logic            clk,
   input  logic            rst,
   cordic_sin_cos_if.slave bus
);
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [31:0] C_DEG90  = 32'd377487360;
   localparam logic [31:0] C_DEG180 = 32'd754974720;
   localparam logic [31:0] C_DEG270 = 32'd1132462080;
   localparam logic [31:0] C_DEG360 = 32'd1509949440;
   localparam logic [31:0] C_DEG720 = 32'd3019898880;
   localparam logic signed [19:0] C_XINIT = 20'sd79594;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_REDUCE  = 3'd2,
      S_ITERATE = 3'd3,
      S_OUTPUT  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic        [31:0] angle_q, angle_d;
   logic        [31:0] mag_q, mag_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;
   logic               ncos_q, ncos_d;
   logic signed [19:0] x_q, x_d, y_q, y_d;
   logic signed [31:0] z_q, z_d;
   logic     [CW-1:0]  it_q, it_d;
   logic signed [15:0] sin_q, sin_d, cos_q, cos_d;
   logic               valid_q, valid_d;

   // atan(2^-i) in degrees, 22 fractional bits
   function automatic logic signed [31:0] atan_lut(input logic [CW-1:0] i);
      int idx;
      idx = int'(i);
      case (idx)
         0:       return 32'sd188743680;
         1:       return 32'sd111421900;
         2:       return 32'sd58872272;
         3:       return 32'sd29884485;
         4:       return 32'sd15000234;
         5:       return 32'sd7507429;
         6:       return 32'sd3754631;
         7:       return 32'sd1877430;
         8:       return 32'sd938729;
         9:       return 32'sd469366;
         10:      return 32'sd234683;
         11:      return 32'sd117342;
         12:      return 32'sd58671;
         13:      return 32'sd29335;
         14:      return 32'sd14668;
         15:      return 32'sd7334;
         default: return 32'sd240315917 >>> idx;
      endcase
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [20:0] v);
      if (v > 21'sd32767)       return 16'sd32767;
      else if (v < -21'sd32768) return -16'sd32768;
      else                      return v[15:0];
   endfunction

   logic        [7:0]  w_exp;
   logic        [31:0] w_man, w_fix;
   logic               w_big;
   logic        [31:0] w_r1, w_r2;
   logic signed [31:0] w_theta;
   logic               w_ncos;
   logic signed [19:0] w_xs, w_ys;
   logic signed [20:0] w_xr, w_yr;

   always_comb begin
      w_exp = angle_q[30:23];
      w_man = {9'd1, angle_q[22:0]};
      w_big = (w_exp >= 8'd137);
      w_fix = '0;
      // value*2^22 = mantissa24 * 2^(exp-128); below exp 105 it truncates to zero
      if (!w_big && w_exp >= 8'd105) begin
         if (w_exp >= 8'd128) w_fix = w_man << (w_exp - 8'd128);
         else                 w_fix = w_man >> (8'd128 - w_exp);
      end

      w_r1 = (mag_q >= C_DEG720) ? mag_q - C_DEG720 : mag_q;
      w_r2 = (w_r1 >= C_DEG360) ? w_r1 - C_DEG360 : w_r1;
      w_ncos = 1'b0;
      if (w_r2 <= C_DEG90) begin
         w_theta = $signed(w_r2);
      end else if (w_r2 <= C_DEG270) begin
         w_theta = $signed(C_DEG180 - w_r2);
         w_ncos  = 1'b1;
      end else begin
         w_theta = $signed(w_r2 - C_DEG360);
      end

      w_xs = x_q >>> it_q;
      w_ys = y_q >>> it_q;
      w_xr = ($signed({x_q[19], x_q}) + 21'sd2) >>> 2;
      w_yr = ($signed({y_q[19], y_q}) + 21'sd2) >>> 2;
   end

   always_comb begin
      state_d = state_q;
      angle_d = angle_q;
      mag_d   = mag_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      ncos_d  = ncos_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      it_d    = it_q;
      sin_d   = sin_q;
      cos_d   = cos_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.valid_in) begin
               angle_d = bus.angle_ieee754;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            mag_d   = w_fix;
            neg_d   = angle_q[31];
            ovf_d   = w_big;
            state_d = S_REDUCE;
         end
         S_REDUCE: begin
            x_d     = C_XINIT;
            y_d     = '0;
            z_d     = w_theta;
            ncos_d  = w_ncos;
            it_d    = '0;
            state_d = S_ITERATE;
         end
         S_ITERATE: begin
            if (!z_q[31]) begin
               x_d = x_q - w_ys;
               y_d = y_q + w_xs;
               z_d = z_q - atan_lut(it_q);
            end else begin
               x_d = x_q + w_ys;
               y_d = y_q - w_xs;
               z_d = z_q + atan_lut(it_q);
            end
            it_d = it_q + 1'b1;
            if (it_q == CW'(ITER - 1)) state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (ovf_q) begin
               sin_d = 16'sd0;
               cos_d = 16'sd32767;
            end else begin
               cos_d = sat16(ncos_q ? -w_xr : w_xr);
               sin_d = sat16(neg_q ? -w_yr : w_yr);
            end
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         angle_q <= '0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         ncos_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         it_q    <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         ncos_q  <= ncos_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         it_q    <= it_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
         valid_q <= valid_d;
      end
   end

   assign bus.sin_q15 = sin_q;
   assign bus.cos_q15 = cos_q;
   assign bus.valid   = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_cordic_sin_cos.sv
`default_nettype none
// ==========================================================================
// tb_cordic_sin_cos : vector table, corner sequences and random model check
// Revision 1.0
// ==========================================================================
module tb_cordic_sin_cos;
   localparam int  ITER = 16;
   localparam int  LAT  = ITER + 3;
   localparam real PI   = 3.14159265358979323846;

   typedef struct {
      logic [31:0] ang;
      int          esin;
      int          ecos;
      int          tol;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   cordic_sin_cos_if bus ();

   cordic_sin_cos #(.ITER(ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp, input int tol);
      checks++;
      if (act > exp + tol || act < exp - tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   function automatic int q15(input real v);
      real s;
      s = v * 32768.0;
      if (s >= 32767.0)  return 32767;
      if (s <= -32768.0) return -32768;
      return int'(s);
   endfunction

   // Reference: decode the float to a real angle and take sin/cos directly
   function automatic void model(input logic [31:0] a, output int es, output int ec,
                                 output int tol);
      int  e;
      real mag, rad;
      e = int'(a[30:23]);
      if (e >= 137) begin
         es = 0; ec = 32767; tol = 0;
         return;
      end
      mag = (e == 0) ? 0.0 : (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      rad = (a[31] ? -mag : mag) * PI / 180.0;
      es  = q15($sin(rad));
      ec  = q15($cos(rad));
      tol = 4;
   endfunction

   function automatic logic [31:0] int2f(input int n);
      int          m, p;
      logic [31:0] r;
      r = '0;
      m = (n < 0) ? -n : n;
      p = 0;
      if (m == 0) return r;
      for (int b = 0; b < 31; b++) if (m[b]) p = b;
      r[31]    = (n < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'((m << (23 - p)) & 32'h7FFFFF);
      return r;
   endfunction

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (bus.valid) cnt++;
      end
   endtask

   task automatic run_op(input logic [31:0] a, output int s, output int c, output int lat);
      @(negedge clk);
      bus.valid_in = 1'b1; bus.angle_ieee754 = a;
      @(posedge clk);
      @(negedge clk);
      bus.valid_in = 1'b0; bus.angle_ieee754 = $urandom;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.valid) begin lat = k; break; end
      end
      s = int'(bus.sin_q15);
      c = int'(bus.cos_q15);
      @(posedge clk); #1;
      chk("valid_one_cycle", int'(bus.valid), 0, 0);
   endtask

   vec_t        tbl [14];
   int          s, c, lat, cnt, es, ec, tol;
   logic [31:0] a;

   initial begin
      clk = 1'b0; rst = 1'b1;
      bus.valid_in = 1'b0; bus.angle_ieee754 = '0;
      checks = 0; failures = 0;

      tbl[0]  = '{32'h00000000,      0,  32767, 4};
      tbl[1]  = '{32'h41F00000,  16384,  28378, 4};
      tbl[2]  = '{32'h42B40000,  32767,      0, 4};
      tbl[3]  = '{32'hC2340000, -23170,  23170, 4};
      tbl[4]  = '{32'h43340000,      0, -32768, 4};
      tbl[5]  = '{32'h43E10000,  32767,      0, 4};
      tbl[6]  = '{32'hC3960000,  28378,  16384, 4};
      tbl[7]  = '{32'h7FC00000,      0,  32767, 0};
      tbl[8]  = '{32'h45000000,      0,  32767, 0};
      tbl[9]  = '{32'h44800000,      0,  32767, 0};
      tbl[10] = '{32'hFF800000,      0,  32767, 0};
      tbl[11] = '{32'h447FC000, -27482,  17847, 4};
      tbl[12] = '{32'h80000000,      0,  32767, 4};
      tbl[13] = '{32'h00000001,      0,  32767, 4};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_sin", int'(bus.sin_q15), 0, 0);
      chk("reset_cos", int'(bus.cos_q15), 0, 0);
      chk("reset_valid", int'(bus.valid), 0, 0);
      @(negedge clk); rst = 1'b0;

      foreach (tbl[i]) begin
         run_op(tbl[i].ang, s, c, lat);
         chk($sformatf("tbl%0d_sin %08h", i, tbl[i].ang), s, tbl[i].esin, tbl[i].tol);
         chk($sformatf("tbl%0d_cos %08h", i, tbl[i].ang), c, tbl[i].ecos, tbl[i].tol);
         chk($sformatf("tbl%0d_latency", i), lat, LAT, 0);
      end

      // Strobe during ITERATE must not disturb the running 30 degree request
      @(negedge clk);
      bus.valid_in = 1'b1; bus.angle_ieee754 = 32'h41F00000;
      @(posedge clk);
      @(negedge clk);
      bus.valid_in = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.valid) begin lat = k; break; end
         if (k == 8) begin bus.valid_in = 1'b1; bus.angle_ieee754 = 32'h42B40000; end
         if (k == 9) bus.valid_in = 1'b0;
      end
      chk("midstrobe_latency", lat, LAT, 0);
      chk("midstrobe_sin", int'(bus.sin_q15), 16384, 4);
      count_valid(30, cnt);
      chk("midstrobe_no_extra_valid", cnt, 0, 0);

      // Reset in the middle of ITERATE aborts and clears the outputs
      @(negedge clk);
      bus.valid_in = 1'b1; bus.angle_ieee754 = 32'hC2340000;
      @(posedge clk);
      @(negedge clk);
      bus.valid_in = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (bus.valid) cnt++;
         if (k == 10) rst = 1'b1;
         if (k == 11) rst = 1'b0;
      end
      chk("midrst_sin", int'(bus.sin_q15), 0, 0);
      chk("midrst_cos", int'(bus.cos_q15), 0, 0);
      count_valid(30, s);
      chk("midrst_no_valid", cnt + s, 0, 0);

      // Reset and strobe together: reset wins, nothing starts
      @(negedge clk);
      rst = 1'b1; bus.valid_in = 1'b1; bus.angle_ieee754 = 32'h41F00000;
      @(negedge clk);
      rst = 1'b0; bus.valid_in = 1'b0;
      count_valid(30, cnt);
      chk("rst_and_strobe_no_valid", cnt, 0, 0);

      // Held strobe: a new angle presented while valid is high starts the next op
      @(negedge clk);
      bus.valid_in = 1'b1; bus.angle_ieee754 = 32'h41F00000;
      @(posedge clk);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.valid) begin lat = k; break; end
      end
      chk("held_first_latency", lat, LAT, 0);
      chk("held_first_cos", int'(bus.cos_q15), 28378, 4);
      bus.angle_ieee754 = 32'hC2340000;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) bus.valid_in = 1'b0;
         if (bus.valid) begin lat = k; break; end
      end
      chk("held_b2b_period", lat, ITER + 4, 0);
      chk("held_second_sin", int'(bus.sin_q15), -23170, 4);
      chk("held_second_cos", int'(bus.cos_q15), 23170, 4);
      count_valid(25, cnt);
      chk("held_stops", cnt, 0, 0);

      // Random requests against the real-arithmetic reference
      for (int n = 0; n < 50; n++) begin
         if (n % 5 == 4) begin
            a = $urandom;
            a[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 104));
         end else begin
            a = int2f(int'($urandom_range(0, 2200)) - 1100);
         end
         model(a, es, ec, tol);
         run_op(a, s, c, lat);
         chk($sformatf("rand_sin %08h", a), s, es, tol);
         chk($sformatf("rand_cos %08h", a), c, ec, tol);
         chk($sformatf("rand_latency %08h", a), lat, LAT, 0);
      end

      for (int d = -360; d <= 360; d++) begin
         pulse_reset();
         a = int2f(d);
         model(a, es, ec, tol);
         run_op(a, s, c, lat);
         chk($sformatf("sweep_sin %0d", d), s, es, tol);
         chk($sformatf("sweep_cos %0d", d), c, ec, tol);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
